// File: rtl/sop_table_scan.sv
// sop_table_scan: walks every row of an N-input truth table, one row per clock,
// emitting the row index, the SoP/PoS function value and a running count of
// true rows, then pulses done with the final count.
module sop_table_scan #(
  parameter int N = 4,
  localparam int M = 1 << N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         mode,
  input  logic [M-1:0] mask,
  input  logic         hold,
  output logic         busy,
  output logic         valid,
  output logic [N-1:0] m,
  output logic         s,
  output logic         done,
  output logic [N:0]   ones
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [N-1:0] LAST_ROW = N'(M - 1);

  state_t       state_q, state_d;
  logic [M-1:0] lmask_q, lmask_d;
  logic         lmode_q, lmode_d;
  logic         busy_q,  busy_d;
  logic         valid_q, valid_d;
  logic [N-1:0] m_q,     m_d;
  logic         s_q,     s_d;
  logic         done_q,  done_d;
  logic [N:0]   ones_q,  ones_d;

  logic [N-1:0] m_inc;
  logic         f_inc;
  logic         f_zero;

  // Row 0 is evaluated from the live inputs because it is emitted on the same
  // edge that latches them; later rows come from the latched copy.
  assign m_inc  = m_q + N'(1);
  assign f_inc  = lmask_q[m_inc] ^ lmode_q;
  assign f_zero = mask[0] ^ mode;

  // Next-state and next-output decode for the scan sequencer.
  always_comb begin
    state_d = state_q;
    lmask_d = lmask_q;
    lmode_d = lmode_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    m_d     = m_q;
    s_d     = s_q;
    done_d  = 1'b0;
    ones_d  = ones_q;

    case (state_q)
      IDLE: begin
        // A start during the done cycle is ignored; the next edge is the first
        // that can launch a new scan.
        if (start && !done_q) begin
          state_d = SCAN;
          lmask_d = mask;
          lmode_d = mode;
          m_d     = '0;
          s_d     = f_zero;
          ones_d  = (N+1)'(f_zero);
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        if (!hold) begin
          if (m_q == LAST_ROW) begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            m_d     = m_inc;
            s_d     = f_inc;
            ones_d  = ones_q + (N+1)'(f_inc);
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous reset has priority over start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lmask_q <= '0;
      lmode_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      m_q     <= '0;
      s_q     <= 1'b0;
      done_q  <= 1'b0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      lmask_q <= lmask_d;
      lmode_q <= lmode_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      m_q     <= m_d;
      s_q     <= s_d;
      done_q  <= done_d;
      ones_q  <= ones_d;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign m     = m_q;
  assign s     = s_q;
  assign done  = done_q;
  assign ones  = ones_q;

endmodule

// File: tb/tb_sop_table_scan.sv
// Bench for sop_table_scan: a truth-table reference model fills scoreboard
// queues at every start; monitors compare each emitted row and done pulse.
module tb_sop_table_scan;

  typedef struct {int m; int s; int ones;} row_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, mode, hold;
  logic [15:0] mask;
  logic        busy, valid, s, done;
  logic [3:0]  m;
  logic [4:0]  ones;

  logic        start2, mode2, hold2;
  logic [3:0]  mask2;
  logic        busy2, valid2, s2, done2;
  logic [1:0]  m2;
  logic [2:0]  ones2;

  sop_table_scan #(.N(4)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .mask(mask),
    .hold(hold), .busy(busy), .valid(valid), .m(m), .s(s), .done(done),
    .ones(ones)
  );

  sop_table_scan #(.N(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .mode(mode2), .mask(mask2),
    .hold(hold2), .busy(busy2), .valid(valid2), .m(m2), .s(s2), .done(done2),
    .ones(ones2)
  );

  int   vectors = 0;
  int   errors  = 0;
  row_t rq[$];
  int   dq[$];
  row_t rq2[$];
  int   dq2[$];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Reference: row i is true when mask bit i differs from mode; rows up to
  // last_row are expected, and the final count only if the scan completes.
  function automatic void expect_scan(input logic [15:0] msk, input logic md,
                                      input int last_row, input bit with_done);
    int cnt;
    int v;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      v = (msk[i] != md) ? 1 : 0;
      cnt += v;
      if (i <= last_row) rq.push_back('{i, v, cnt});
    end
    if (with_done) dq.push_back(cnt);
  endfunction

  // Monitor for the N=4 instance.
  row_t mon_r = '{0, 0, 0};
  logic prev_done = 1'b0;
  always @(posedge clk) begin
    #1;
    if (valid) begin
      if (rq.size() == 0) begin
        vectors++; errors++;
        $display("FAIL unexpected_row: got row m=%0d, required no row", m);
      end else begin
        mon_r = rq.pop_front();
        chk("row_m", m, mon_r.m);
        chk("row_s", s, mon_r.s);
        chk("row_ones", ones, mon_r.ones);
        chk("row_busy", busy, 1);
      end
    end else if (busy) begin
      chk("hold_m", m, mon_r.m);
      chk("hold_ones", ones, mon_r.ones);
    end
    if (done) begin
      if (dq.size() == 0) begin
        vectors++; errors++;
        $display("FAIL unexpected_done: got done with ones=%0d, required no done", ones);
      end else begin
        chk("done_ones", ones, dq.pop_front());
      end
      chk("done_busy", busy, 0);
      chk("done_valid", valid, 0);
      chk("done_width", prev_done, 0);
    end
    prev_done = done;
  end

  // Monitor for the N=2 instance.
  row_t mon_r2 = '{0, 0, 0};
  always @(posedge clk) begin
    #1;
    if (valid2) begin
      if (rq2.size() == 0) begin
        vectors++; errors++;
        $display("FAIL unexpected_row2: got row m=%0d, required no row", m2);
      end else begin
        mon_r2 = rq2.pop_front();
        chk("row2_m", m2, mon_r2.m);
        chk("row2_s", s2, mon_r2.s);
        chk("row2_ones", ones2, mon_r2.ones);
      end
    end
    if (done2) begin
      if (dq2.size() == 0) begin
        vectors++; errors++;
        $display("FAIL unexpected_done2: got done with ones=%0d, required no done", ones2);
      end else begin
        chk("done2_ones", ones2, dq2.pop_front());
      end
    end
  end

  // Caller is at a negedge; returns one cycle after the done pulse.
  task automatic run_scan(input logic [15:0] msk, input logic md,
                          input int hold_at, input int hold_len, input int poke_at);
    int cnt;
    expect_scan(msk, md, 15, 1'b1);
    mask  = msk;
    mode  = md;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt   = 0;
    while (!done && cnt < 200) begin
      if (valid && int'(m) == hold_at) begin
        hold = 1'b1;
        repeat (hold_len) begin
          @(negedge clk);
          cnt++;
        end
        hold = 1'b0;
      end else if (valid && int'(m) == poke_at) begin
        start = 1'b1;
        mask  = 16'hFFFF;
        mode  = ~md;
      end
      @(negedge clk);
      cnt++;
      start = 1'b0;
    end
    chk("done_latency", cnt, 16 + ((hold_at >= 0) ? hold_len : 0));
    @(negedge clk);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"},  busy,  0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_m"},     m,     0);
    chk({tag, "_s"},     s,     0);
    chk({tag, "_done"},  done,  0);
    chk({tag, "_ones"},  ones,  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int h;
    logic [15:0] rm;
    logic        rmd;

    reset = 1'b1; start = 1'b0; mode = 1'b0; hold = 1'b0; mask = '0;
    start2 = 1'b0; mode2 = 1'b0; hold2 = 1'b0; mask2 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_idle_zero("reset");
    chk("reset2_busy", busy2, 0);
    chk("reset2_ones", ones2, 0);

    // Hold in IDLE must have no effect.
    hold = 1'b1;
    @(negedge clk);
    hold = 1'b0;
    chk_idle_zero("idle_hold");

    run_scan(16'h1894, 1'b0, -1, 0, -1);
    run_scan(16'h1894, 1'b1, -1, 0, -1);
    run_scan(16'h1894, 1'b0, 6, 3, -1);
    run_scan(16'h1894, 1'b0, -1, 0, 5);
    run_scan(16'hFFFF, 1'b0, -1, 0, -1);
    run_scan(16'h1894, 1'b0, 15, 2, -1);

    // Reset while scanning at row 9: rows 0..9 only, no done afterwards.
    expect_scan(16'h1894, 1'b0, 9, 1'b0);
    mask = 16'h1894; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!(valid && m == 4'd9) && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("reach_row9", cnt, 9);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle_zero("mid_reset");
    repeat (25) @(negedge clk);
    chk_idle_zero("post_reset");

    // Reset and start together: reset wins.
    reset = 1'b1; start = 1'b1; mask = 16'hFFFF;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk_idle_zero("reset_start");
    @(negedge clk);
    chk_idle_zero("reset_start2");

    // N=2 instance, mask 1000b.
    rq2.push_back('{0, 0, 0});
    rq2.push_back('{1, 0, 0});
    rq2.push_back('{2, 0, 0});
    rq2.push_back('{3, 1, 1});
    dq2.push_back(1);
    mask2 = 4'b1000; mode2 = 1'b0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cnt = 0;
    while (!done2 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("n2_latency", cnt, 4);
    @(negedge clk);
    chk("n2_busy_after", busy2, 0);

    // Randomised scans with optional holds.
    for (int i = 0; i < 10; i++) begin
      rm  = 16'($urandom);
      rmd = 1'($urandom_range(0, 1));
      h   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1;
      run_scan(rm, rmd, h, int'($urandom_range(1, 4)), -1);
    end

    repeat (3) @(negedge clk);
    chk("rows_pending", rq.size(), 0);
    chk("done_pending", dq.size(), 0);
    chk("rows2_pending", rq2.size(), 0);
    chk("done2_pending", dq2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
